// File: rtl/acc_arbiter.sv
// Two-requester round-robin arbiter feeding one shared registered accumulator.
// Each grant accumulates a burst of words and reports the sum with a sticky carry flag.
module acc_arbiter #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_req,
  input  logic [1:0]       i_last,
  input  logic [WIDTH-1:0] i_data0,
  input  logic [WIDTH-1:0] i_data1,
  output logic [1:0]       o_gnt,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_owner,
  output logic             o_ovf,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_LEN);

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             out_owner_q, out_owner_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;

  logic             own_req_s;
  logic             own_last_s;
  logic [WIDTH-1:0] own_data_s;
  logic [WIDTH:0]   sum_s;
  logic [7:0]       cnt_inc_s;
  logic             winner_s;

  // Only the current owner's inputs reach the adder; the other requester is ignored.
  assign own_req_s  = i_req[owner_q];
  assign own_last_s = i_last[owner_q];
  assign own_data_s = owner_q ? i_data1 : i_data0;
  assign sum_s      = {1'b0, acc_q} + {1'b0, own_data_s};
  assign cnt_inc_s  = cnt_q + 8'd1;
  // With both requesting, the pointer names the requester not served last.
  assign winner_s   = (i_req == 2'b11) ? ptr_q : i_req[1];

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sticky_d    = sticky_q;
    gnt_d       = gnt_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    out_owner_d = out_owner_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: begin
        if (i_req != 2'b00) begin
          state_d  = ACC;
          owner_d  = winner_s;
          gnt_d    = winner_s ? 2'b10 : 2'b01;
          acc_d    = '0;
          cnt_d    = 8'd0;
          sticky_d = 1'b0;
        end else begin
          gnt_d = 2'b00;
        end
      end
      ACC: begin
        if (own_req_s) begin
          acc_d    = sum_s[WIDTH-1:0];
          cnt_d    = cnt_inc_s;
          sticky_d = sticky_q | sum_s[WIDTH];
          // A last marker coinciding with the length limit is one ordinary end.
          if (own_last_s || (cnt_inc_s >= MAX_CNT)) begin
            state_d     = DONE;
            gnt_d       = 2'b00;
            valid_d     = 1'b1;
            data_d      = sum_s[WIDTH-1:0];
            out_owner_d = owner_q;
            ovf_d       = sticky_q | sum_s[WIDTH];
          end else begin
            state_d = ACC;
          end
        end else begin
          state_d = IDLE;
          gnt_d   = 2'b00;
          ptr_d   = ~owner_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        ptr_d   = ~owner_q;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      ptr_q       <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= 8'd0;
      sticky_q    <= 1'b0;
      gnt_q       <= 2'b00;
      data_q      <= '0;
      valid_q     <= 1'b0;
      out_owner_q <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sticky_q    <= sticky_d;
      gnt_q       <= gnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      out_owner_q <= out_owner_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
    end
  end

  assign o_gnt   = gnt_q;
  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_owner = out_owner_q;
  assign o_ovf   = ovf_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_acc_arbiter.sv
// Directed bench for acc_arbiter (WIDTH=8, MAX_LEN=16) with hand-computed expectations.
module tb_acc_arbiter;

  logic       i_clk;
  logic       i_rst;
  logic [1:0] i_req;
  logic [1:0] i_last;
  logic [7:0] i_data0;
  logic [7:0] i_data1;
  logic [1:0] o_gnt;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_owner;
  logic       o_ovf;
  logic       o_busy;

  int n_chk  = 0;
  int n_fail = 0;

  acc_arbiter #(.WIDTH(8), .MAX_LEN(16)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_req  (i_req),
    .i_last (i_last),
    .i_data0(i_data0),
    .i_data1(i_data1),
    .o_gnt  (o_gnt),
    .o_data (o_data),
    .o_valid(o_valid),
    .o_owner(o_owner),
    .o_ovf  (o_ovf),
    .o_busy (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_result(input string tag, input logic [7:0] d, input logic ow, input logic ov);
    chk({tag, "_valid"}, 32'(o_valid), 32'd1);
    chk({tag, "_data"},  32'(o_data),  32'(d));
    chk({tag, "_owner"}, 32'(o_owner), 32'(ow));
    chk({tag, "_ovf"},   32'(o_ovf),   32'(ov));
    chk({tag, "_gnt"},   32'(o_gnt),   32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_gnt"},   32'(o_gnt),   32'd0);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_data"},  32'(o_data),  32'd0);
    chk({tag, "_owner"}, 32'(o_owner), 32'd0);
    chk({tag, "_ovf"},   32'(o_ovf),   32'd0);
    chk({tag, "_busy"},  32'(o_busy),  32'd0);
  endtask

  initial begin
    i_rst = 1'b1; i_req = 2'b00; i_last = 2'b00; i_data0 = 8'd0; i_data1 = 8'd0;
    tick(); tick();
    chk_reset("rst");
    i_rst = 1'b0;
    tick();
    chk("idle_busy", 32'(o_busy), 32'd0);

    // Requester 0 alone: 3+5+7.
    i_req = 2'b01; i_data0 = 8'd3;
    tick();
    chk("r0_gnt", 32'(o_gnt), 32'd1);
    chk("r0_busy", 32'(o_busy), 32'd1);
    tick();
    i_data0 = 8'd5;
    tick();
    chk("r0_novalid", 32'(o_valid), 32'd0);
    i_data0 = 8'd7; i_last = 2'b01;
    tick();
    chk_result("r0", 8'd15, 1'b0, 1'b0);
    i_req = 2'b00; i_last = 2'b00;
    tick();
    chk("r0_valid_drop", 32'(o_valid), 32'd0);
    chk("r0_data_hold", 32'(o_data), 32'd15);
    chk("r0_busy_low", 32'(o_busy), 32'd0);

    // Requester 1: 200+100 wraps to 44 with carry.
    i_req = 2'b10; i_data1 = 8'd200;
    tick();
    chk("r1_gnt", 32'(o_gnt), 32'd2);
    tick();
    i_data1 = 8'd100; i_last = 2'b10;
    tick();
    chk_result("r1", 8'd44, 1'b1, 1'b1);
    i_req = 2'b00; i_last = 2'b00;
    tick();
    chk("r1_ovf_hold", 32'(o_ovf), 32'd1);

    // Both requesting: two-word bursts alternate owners with one idle cycle between.
    i_req = 2'b11; i_data0 = 8'd1; i_data1 = 8'd2;
    tick();
    chk("rr_gnt_a", 32'(o_gnt), 32'd1);
    tick();
    i_last = 2'b11;
    tick();
    chk_result("rr_a", 8'd2, 1'b0, 1'b0);
    i_last = 2'b00;
    tick();
    chk("rr_gap_a", 32'(o_gnt), 32'd0);
    chk("rr_gap_a_busy", 32'(o_busy), 32'd0);
    tick();
    chk("rr_gnt_b", 32'(o_gnt), 32'd2);
    tick();
    i_last = 2'b11;
    tick();
    chk_result("rr_b", 8'd4, 1'b1, 1'b0);
    i_last = 2'b00;
    tick();
    chk("rr_gap_b", 32'(o_gnt), 32'd0);
    tick();
    chk("rr_gnt_c", 32'(o_gnt), 32'd1);
    tick();
    i_last = 2'b11;
    tick();
    chk_result("rr_c", 8'd2, 1'b0, 1'b0);
    i_req = 2'b00; i_last = 2'b00;
    tick();

    // 20 words of 1 without last: forced end after 16, remainder re-arbitrated.
    i_req = 2'b01; i_data0 = 8'd1;
    tick();
    chk("max_gnt", 32'(o_gnt), 32'd1);
    for (int i = 0; i < 15; i++) tick();
    chk("max_15_novalid", 32'(o_valid), 32'd0);
    tick();
    chk_result("max16", 8'd16, 1'b0, 1'b0);
    tick();
    chk("max_gap_gnt", 32'(o_gnt), 32'd0);
    chk("max_gap_valid", 32'(o_valid), 32'd0);
    tick();
    chk("max_regnt", 32'(o_gnt), 32'd1);
    tick(); tick(); tick();
    i_last = 2'b01;
    tick();
    chk_result("max_rest", 8'd4, 1'b0, 1'b0);
    i_req = 2'b00; i_last = 2'b00;
    tick();

    // Abort: requester 0 drops after two words while requester 1 waits.
    i_req = 2'b01; i_data0 = 8'd9; i_data1 = 8'd9;
    tick();
    chk("ab_gnt0", 32'(o_gnt), 32'd1);
    i_req = 2'b11;
    tick(); tick();
    i_req = 2'b10;
    tick();
    chk("ab_busy", 32'(o_busy), 32'd0);
    chk("ab_valid", 32'(o_valid), 32'd0);
    chk("ab_gnt_off", 32'(o_gnt), 32'd0);
    chk("ab_data_hold", 32'(o_data), 32'd4);
    tick();
    chk("ab_gnt1", 32'(o_gnt), 32'd2);
    i_last = 2'b10;
    tick();
    chk_result("ab_r1", 8'd9, 1'b1, 1'b0);
    i_req = 2'b00; i_last = 2'b00;
    tick();

    // Asynchronous reset in the middle of a burst.
    i_req = 2'b01; i_data0 = 8'd5;
    tick();
    tick(); tick(); tick();
    chk("mid_busy", 32'(o_busy), 32'd1);
    i_rst = 1'b1; i_req = 2'b00;
    #1;
    chk_reset("mid_rst");
    tick();
    i_rst = 1'b0; i_req = 2'b01; i_data0 = 8'd4;
    tick();
    chk("post_rst_gnt", 32'(o_gnt), 32'd1);
    tick();
    i_last = 2'b01;
    tick();
    chk_result("post_rst", 8'd8, 1'b0, 1'b0);
    i_req = 2'b00; i_last = 2'b00;
    tick();

    // Last marker on the 16th word: exactly one result.
    i_req = 2'b01; i_data0 = 8'd2;
    tick();
    for (int i = 0; i < 15; i++) tick();
    i_last = 2'b01;
    tick();
    chk_result("last_max", 8'd32, 1'b0, 1'b0);
    i_req = 2'b00; i_last = 2'b00;
    tick();
    chk("last_max_once_a", 32'(o_valid), 32'd0);
    chk("last_max_idle", 32'(o_busy), 32'd0);
    tick();
    chk("last_max_once_b", 32'(o_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
